// File: rtl/rv32i_wb_sram_slave.sv
// Wishbone B4 pipelined slave over a word-addressed on-chip SRAM with a fixed-latency response pipeline.
// Optional random back-pressure: define RV32I_WB_STALL_INJECT_EN.
module rv32i_wb_sram_slave #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);
  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [31:0]         mem [DEPTH];
  logic [31:0]         offset;
  logic                in_range;
  logic [AW-1:0]       word_idx;
  logic                accept;
  logic                resp;

  logic [LATENCY-1:0]  vld_q;
  logic [LATENCY-1:0]  err_q;
  logic [31:0]         dat_q [LATENCY];
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset   = wb_adr_i - BASE_ADDR;
  assign in_range = offset < WIN_BYTES;
  assign word_idx = offset[AW+1:2];
  assign accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign resp     = vld_q[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 samples the SRAM at the accept edge, so a read sees every earlier accepted write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < int'(LATENCY); s++) begin
        dat_q[s] <= '0;
      end
    end else if (!wb_cyc_i) begin
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < int'(LATENCY); s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & ~in_range;
      dat_q[0] <= (accept && !wb_we_i && in_range) ? mem[word_idx] : 32'h0;
      for (int s = 1; s < int'(LATENCY); s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign wb_ack_o = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
  assign wb_err_o = vld_q[LATENCY-1] &  err_q[LATENCY-1];
  assign wb_dat_o = dat_q[LATENCY-1];

  always_comb begin
    cnt_d = cnt_q;
    if (!wb_cyc_i) begin
      cnt_d = '0;
    end else if (accept && !resp) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && resp) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef RV32I_WB_STALL_INJECT_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       inject;

  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign inject = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign wb_stall_o = (cnt_q == CNT_MAX) | inject;
`else
  assign wb_stall_o = (cnt_q == CNT_MAX);
`endif

endmodule
